psram_bus_bridge: RTL and testbench

- Upstream stage of the SPI PSRAM memory controller: takes RV32 core load/store requests and turns them into whole-word PSRAM transactions.
- Accepts one request at a time on a valid/ready handshake.
- Partial-word stores (byte/halfword strobes) become a read-modify-write sequence; full-word stores go straight to a write.
- Flags misaligned addresses and watchdog timeouts on the response channel.

---
 rtl/psram_bus_bridge_if.sv | 31 +++
 rtl/psram_bus_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_psram_bus_bridge.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_bus_bridge_if.sv
// Bus bundle of the PSRAM bridge: core request/response channel plus the
// whole-word transaction channel towards the SPI PSRAM controller.
interface psram_bus_bridge_if #(
    parameter int ADDR_W = 24
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [3:0]        req_wstrb;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_we, req_wstrb, req_wdata, mem_done, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_addr, req_we, req_wstrb, req_wdata, mem_done, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/psram_bus_bridge.sv
// Turns single RV32 load/store requests into whole-word PSRAM transactions,
// using read-modify-write for partial stores and a watchdog on each transaction.
module psram_bus_bridge #(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    psram_bus_bridge_if.slave bus
);
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic              we_r, we_s;
    logic [3:0]        wstrb_r, wstrb_s;
    logic [31:0]       wdata_r, wdata_s;
    logic              gap_r, gap_s;
    logic [WD_W-1:0]   wdog_r, wdog_s;
    logic              req_ready_r, req_ready_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic [31:0]       rsp_rdata_r, rsp_rdata_s;
    logic              rsp_err_r, rsp_err_s;
    logic              mem_req_r, mem_req_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [31:0]       mem_wdata_r, mem_wdata_s;
    logic              done_s;
    logic              expire_s;

    function automatic logic [31:0] merge_bytes(input logic [3:0]  strb,
                                                input logic [31:0] new_w,
                                                input logic [31:0] old_w);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return merged;
    endfunction

    // A completion pulse only counts while a transaction is outstanding, and it beats expiry.
    assign done_s   = mem_req_r & bus.mem_done;
    assign expire_s = mem_req_r & ~bus.mem_done & (wdog_r == WD_LAST);

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_s     = state_r;
        we_s        = we_r;
        wstrb_s     = wstrb_r;
        wdata_s     = wdata_r;
        gap_s       = gap_r;
        req_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        case (state_r)
            IDLE: begin
                req_ready_s = 1'b1;
                if (req_ready_r && bus.req_valid) begin
                    req_ready_s = 1'b0;
                    we_s        = bus.req_we;
                    wstrb_s     = bus.req_wstrb;
                    wdata_s     = bus.req_wdata;
                    mem_addr_s  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    rsp_rdata_s = 32'h0000_0000;
                    rsp_err_s   = 1'b0;
                    if (bus.req_addr[1:0] != 2'b00) begin
                        rsp_err_s = 1'b1;
                        state_s   = RESP;
                    end else if (bus.req_we && (bus.req_wstrb == 4'h0)) begin
                        state_s = RESP;
                    end else if (bus.req_we && (bus.req_wstrb == 4'hF)) begin
                        mem_req_s   = 1'b1;
                        mem_we_s    = 1'b1;
                        mem_wdata_s = bus.req_wdata;
                        state_s     = WR;
                    end else begin
                        mem_req_s = 1'b1;
                        mem_we_s  = 1'b0;
                        state_s   = RD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                if (done_s) begin
                    mem_req_s = 1'b0;
                    if (we_r) begin
                        // Partial store: merged word goes out after a one-cycle request gap.
                        mem_we_s    = 1'b1;
                        mem_wdata_s = merge_bytes(wstrb_r, wdata_r, bus.mem_rdata);
                        gap_s       = 1'b1;
                        state_s     = WR;
                    end else begin
                        rsp_rdata_s = bus.mem_rdata;
                        state_s     = RESP;
                    end
                end else if (expire_s) begin
                    mem_req_s   = 1'b0;
                    rsp_err_s   = 1'b1;
                    rsp_rdata_s = 32'h0000_0000;
                    state_s     = RESP;
                end else begin
                    state_s = RD;
                end
            end
            WR: begin
                if (gap_r) begin
                    gap_s     = 1'b0;
                    mem_req_s = 1'b1;
                end else if (done_s) begin
                    mem_req_s   = 1'b0;
                    rsp_rdata_s = 32'h0000_0000;
                    state_s     = RESP;
                end else if (expire_s) begin
                    mem_req_s   = 1'b0;
                    rsp_err_s   = 1'b1;
                    rsp_rdata_s = 32'h0000_0000;
                    state_s     = RESP;
                end else begin
                    state_s = WR;
                end
            end
            RESP: begin
                rsp_valid_s = 1'b1;
                state_s     = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Watchdog restarts on each request rising edge and counts stalled cycles.
    always_comb begin
        wdog_s = wdog_r;
        if (mem_req_s && !mem_req_r) begin
            wdog_s = {WD_W{1'b0}};
        end else if (mem_req_r && !bus.mem_done) begin
            wdog_s = wdog_r + WD_W'(1);
        end else begin
            wdog_s = wdog_r;
        end
    end

    // State, holding and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            we_r        <= 1'b0;
            wstrb_r     <= 4'h0;
            wdata_r     <= 32'h0000_0000;
            gap_r       <= 1'b0;
            wdog_r      <= {WD_W{1'b0}};
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            we_r        <= we_s;
            wstrb_r     <= wstrb_s;
            wdata_r     <= wdata_s;
            gap_r       <= gap_s;
            wdog_r      <= wdog_s;
            req_ready_r <= req_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
endmodule

// File: tb/tb_psram_bus_bridge.sv
// Bench for psram_bus_bridge: vector table on a default-timeout instance with a
// PSRAM model, plus hand sequences for reset mid-read and a 16-cycle watchdog instance.
module tb_psram_bus_bridge;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    psram_bus_bridge_if #(.ADDR_W(24)) bus_a ();
    psram_bus_bridge_if #(.ADDR_W(24)) bus_b ();

    psram_bus_bridge #(.ADDR_W(24), .TIMEOUT(1023)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    psram_bus_bridge #(.ADDR_W(24), .TIMEOUT(16))   dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_ntr;
        logic [31:0] exp_wr;
        int          exp_lat;
    } vec_t;

    vec_t vt [10];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PSRAM model state for dut_a
    logic [31:0] mem [0:255];
    bit          loaded = 1'b0;
    int          lat_a = 1;
    bit          silent_a = 1'b0;
    int          inject_req = 0;
    int          inject_seen = 0;
    bit          active_a = 1'b0;
    int          cnt_a = 0;
    int          low_run_a = 100;
    int          n_tr = 0;
    logic        tr_we   [0:63];
    logic [23:0] tr_addr [0:63];
    logic [31:0] tr_wdata[0:63];
    int          tr_gap  [0:63];

    // Answers each dut_a transaction lat_a cycles after the request rises and logs it.
    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] = 32'h0;
            mem[0] = 32'hDEADBEEF;
            mem[2] = 32'h11223344;
            bus_a.mem_rdata = 32'h0;
            loaded = 1'b1;
        end
        bus_a.mem_done = 1'b0;
        if (inject_seen != inject_req) begin
            bus_a.mem_done = 1'b1;
            inject_seen = inject_req;
        end
        if (bus_a.mem_req) begin
            if (!active_a) begin
                active_a = 1'b1;
                cnt_a = 0;
                if (n_tr < 64) begin
                    tr_we[n_tr]    = bus_a.mem_we;
                    tr_addr[n_tr]  = bus_a.mem_addr;
                    tr_wdata[n_tr] = bus_a.mem_wdata;
                    tr_gap[n_tr]   = low_run_a;
                    n_tr++;
                end
            end
            cnt_a++;
            low_run_a = 0;
            if (cnt_a == lat_a && !silent_a) begin
                bus_a.mem_done = 1'b1;
                if (bus_a.mem_we) mem[bus_a.mem_addr[9:2]] = bus_a.mem_wdata;
                else              bus_a.mem_rdata = mem[bus_a.mem_addr[9:2]];
            end
        end else begin
            active_a = 1'b0;
            low_run_a++;
        end
    end

    int          n_rsp_a = 0, rsp_cyc_a = 0, ready_in_rsp_a = 0;
    logic [31:0] rsp_rdata_a = 32'h0;
    logic        rsp_err_a = 1'b0;
    int          n_rsp_b = 0, rises_b = 0;
    logic        prev_req_b = 1'b0;
    logic [31:0] rsp_rdata_b = 32'h0;
    logic        rsp_err_b = 1'b0;

    // Response monitors for both instances.
    always @(negedge clk) begin
        if (bus_a.rsp_valid === 1'b1) begin
            n_rsp_a++;
            rsp_cyc_a   = cyc;
            rsp_rdata_a = bus_a.rsp_rdata;
            rsp_err_a   = bus_a.rsp_err;
            if (bus_a.req_ready === 1'b1) ready_in_rsp_a++;
        end
        if (bus_b.rsp_valid === 1'b1) begin
            n_rsp_b++;
            rsp_rdata_b = bus_b.rsp_rdata;
            rsp_err_b   = bus_b.rsp_err;
        end
        if (bus_b.mem_req === 1'b1 && prev_req_b !== 1'b1) rises_b++;
        prev_req_b = bus_b.mem_req;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue_a(input logic we, input logic [23:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata, output int acc_cyc, output bit ok);
        int w = 0;
        @(negedge clk);
        bus_a.req_valid = 1'b1;
        bus_a.req_we    = we;
        bus_a.req_addr  = addr;
        bus_a.req_wstrb = strb;
        bus_a.req_wdata = wdata;
        while (bus_a.req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = (bus_a.req_ready === 1'b1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        bus_a.req_we    = ~we;
        bus_a.req_addr  = ~addr;
        bus_a.req_wstrb = ~strb;
        bus_a.req_wdata = ~wdata;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  n0, t0, acc, w;
        bit  ok;
        n0 = n_rsp_a;
        t0 = n_tr;
        lat_a = v.lat;
        issue_a(v.we, v.addr, v.strb, v.wdata, acc, ok);
        check32({tag, ".accept"}, {31'd0, ok}, 32'd1);
        w = 0;
        while (n_rsp_a == n0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        check32({tag, ".n_rsp"}, n_rsp_a - n0, 32'd1);
        check32({tag, ".rdata"}, rsp_rdata_a, v.exp_rdata);
        check32({tag, ".err"}, {31'd0, rsp_err_a}, {31'd0, v.exp_err});
        check32({tag, ".n_mem"}, n_tr - t0, v.exp_ntr);
        check32({tag, ".latency"}, rsp_cyc_a - acc, v.exp_lat);
        for (int k = t0; k < n_tr; k++)
            check32({tag, ".mem_addr"}, {8'd0, tr_addr[k]}, {8'd0, v.addr[23:2], 2'b00});
        if (v.exp_ntr > 0 && n_tr > 0) begin
            check32({tag, ".last_we"}, {31'd0, tr_we[n_tr-1]}, {31'd0, v.we});
            if (v.we) check32({tag, ".mem_wdata"}, tr_wdata[n_tr-1], v.exp_wr);
        end
        if (v.exp_ntr == 2 && n_tr == t0 + 2) begin
            check32({tag, ".rmw_first_read"}, {31'd0, tr_we[t0]}, 32'd0);
            check32({tag, ".rmw_gap"}, tr_gap[t0+1], 32'd1);
        end
    endtask

    task automatic b_txn(input logic we, input logic [23:0] addr, input logic [3:0] strb,
                         input int done_at, input logic [31:0] rdata, output int hi, output bit ok);
        int w;
        int n0;
        n0 = n_rsp_b;
        @(negedge clk);
        bus_b.req_valid = 1'b1;
        bus_b.req_we    = we;
        bus_b.req_addr  = addr;
        bus_b.req_wstrb = strb;
        bus_b.req_wdata = 32'h5555AAAA;
        w = 0;
        while (bus_b.req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        bus_b.req_valid = 1'b0;
        hi = 0;
        w = 0;
        @(negedge clk);
        while (bus_b.mem_req === 1'b1 && w < 100) begin
            hi++;
            bus_b.mem_done  = (hi == done_at);
            bus_b.mem_rdata = rdata;
            @(negedge clk);
            w++;
        end
        bus_b.mem_done = 1'b0;
        w = 0;
        while (n_rsp_b == n0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = (n_rsp_b == n0 + 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int  hi, acc, r0, n0;
        bit  ok;
        vec_t rv;

        //       we    addr        strb  wdata         lat rdata         err  ntr wr            lat
        vt[0] = '{1'b0, 24'h008000, 4'h0, 32'h00000000, 70, 32'hDEADBEEF, 1'b0, 1, 32'h00000000, 72};
        vt[1] = '{1'b1, 24'h008004, 4'hF, 32'hF0F0F0F0,  5, 32'h00000000, 1'b0, 1, 32'hF0F0F0F0,  7};
        vt[2] = '{1'b1, 24'h008008, 4'h5, 32'hAABBCCDD,  3, 32'h00000000, 1'b0, 2, 32'h11BB33DD,  9};
        vt[3] = '{1'b0, 24'h008002, 4'h0, 32'h00000000,  1, 32'h00000000, 1'b1, 0, 32'h00000000,  2};
        vt[4] = '{1'b1, 24'h00800C, 4'h0, 32'h12345678,  1, 32'h00000000, 1'b0, 0, 32'h00000000,  2};
        vt[5] = '{1'b0, 24'h008004, 4'h0, 32'h00000000,  1, 32'hF0F0F0F0, 1'b0, 1, 32'h00000000,  3};
        vt[6] = '{1'b0, 24'h008008, 4'h0, 32'h00000000,  2, 32'h11BB33DD, 1'b0, 1, 32'h00000000,  4};
        vt[7] = '{1'b1, 24'h008000, 4'h8, 32'h12345678,  4, 32'h00000000, 1'b0, 2, 32'h12ADBEEF, 11};
        vt[8] = '{1'b1, 24'h008001, 4'hF, 32'hFFFFFFFF,  1, 32'h00000000, 1'b1, 0, 32'h00000000,  2};
        vt[9] = '{1'b0, 24'h008000, 4'h0, 32'h00000000,  1, 32'h12ADBEEF, 1'b0, 1, 32'h00000000,  3};

        reset = 1'b1;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = 24'h0;
        bus_a.req_wstrb = 4'h0; bus_a.req_wdata = 32'h0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = 24'h0;
        bus_b.req_wstrb = 4'h0; bus_b.req_wdata = 32'h0;
        bus_b.mem_done = 1'b0; bus_b.mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset.ctl", {27'd0, bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err,
                              bus_a.mem_req, bus_a.mem_we}, 32'd0);
        check32("reset.rsp_rdata", bus_a.rsp_rdata, 32'd0);
        check32("reset.mem_addr", {8'd0, bus_a.mem_addr}, 32'd0);
        check32("reset.mem_wdata", bus_a.mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Reset while a read is outstanding, then a stray completion pulse.
        silent_a = 1'b1;
        issue_a(1'b0, 24'h008010, 4'h0, 32'h0, acc, ok);
        n0 = n_rsp_a;
        repeat (3) @(negedge clk);
        check32("rstmid.in_rd", {31'd0, bus_a.mem_req}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check32("rstmid.ctl", {27'd0, bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err,
                               bus_a.mem_req, bus_a.mem_we}, 32'd0);
        check32("rstmid.mem_addr", {8'd0, bus_a.mem_addr}, 32'd0);
        check32("rstmid.rsp_rdata", bus_a.rsp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check32("rstmid.ready", {31'd0, bus_a.req_ready}, 32'd1);
        inject_req++;
        repeat (4) @(negedge clk);
        check32("rstmid.no_rsp", n_rsp_a - n0, 32'd0);
        check32("rstmid.idle", {30'd0, bus_a.mem_req, bus_a.req_ready}, 32'd1);
        silent_a = 1'b0;
        rv = vt[5];
        run_vec(rv, "after_reset");

        // Watchdog instance: expiry, recovery, tie with expiry, RMW abort.
        r0 = rises_b;
        b_txn(1'b0, 24'h000010, 4'h0, 0, 32'h0, hi, ok);
        check32("wd.rsp", {31'd0, ok}, 32'd1);
        check32("wd.req_cycles", hi, 32'd16);
        check32("wd.err", {31'd0, rsp_err_b}, 32'd1);
        check32("wd.rdata", rsp_rdata_b, 32'd0);
        b_txn(1'b0, 24'h000014, 4'h0, 3, 32'hCAFEF00D, hi, ok);
        check32("wd_next.rsp", {31'd0, ok}, 32'd1);
        check32("wd_next.req_cycles", hi, 32'd3);
        check32("wd_next.rdata", rsp_rdata_b, 32'hCAFEF00D);
        check32("wd_next.err", {31'd0, rsp_err_b}, 32'd0);
        b_txn(1'b0, 24'h000018, 4'h0, 16, 32'h0BADC0DE, hi, ok);
        check32("wd_tie.req_cycles", hi, 32'd16);
        check32("wd_tie.rdata", rsp_rdata_b, 32'h0BADC0DE);
        check32("wd_tie.err", {31'd0, rsp_err_b}, 32'd0);
        r0 = rises_b;
        b_txn(1'b1, 24'h000020, 4'h1, 0, 32'h0, hi, ok);
        check32("wd_rmw.rsp", {31'd0, ok}, 32'd1);
        check32("wd_rmw.req_cycles", hi, 32'd16);
        check32("wd_rmw.no_write", rises_b - r0, 32'd1);
        check32("wd_rmw.err", {31'd0, rsp_err_b}, 32'd1);

        check32("ready_during_rsp", ready_in_rsp_a, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
